regfile_write_port: RTL and testbench
=====================================

Name: regfile_write_port

Overview:
- Write side of the 32 x 32-bit general register file.
- Accepts write-back requests over a valid/ready handshake and buffers them in a 2-entry queue.
- Decodes the 5-bit destination address to a one-hot enable and commits one write per cycle into 32 registers.
- Exposes all 32 register values in parallel on Q0..Q31, which feed the 32-to-1 read multiplexers.
- Also provides a sequenced bulk-clear operation.

Parameters:
- WIDTH, 32, data width of each register.
- ZERO_REG, 1, when 1 register 0 reads constant 0 and writes to it are dropped.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_valid  input  1  write request present.
- wr_ready  output  1  request accepted on the edge where wr_valid&wr_ready.
- wr_addr  input  5  destination register number.
- wr_data  input  WIDTH  data to write.
- clr_req  input  1  bulk-clear request; level, sampled in IDLE.
- clr_done  output  1  one-cycle pulse when a sweep completes.
- busy  output  1  high whenever state is not IDLE or the queue is non-empty.
- Q0..Q31  output  WIDTH each  current register contents.

Behaviour:
- Reset (reset=1 at a clock edge):
  - All Q* = 0, queue emptied, state = IDLE, clr_done = 0.
  - Reset overrides any in-flight write or sweep on that edge.
  - After reset: wr_ready = 1, busy = 0.
- Queue:
  - 2-entry FIFO of {addr, data}.
  - wr_ready = (state==IDLE) && (count<2).
- Commit timing:
  - A request accepted at edge N is committed at edge N+1 at the earliest, one entry per edge, oldest first.
  - Q reflects the write after that edge.
  - Back-to-back accepts therefore sustain 1 write/cycle with constant occupancy 1.
- Simultaneous accept and commit on the same edge: count unchanged; the new entry goes behind the head.
- Decode:
  - wr_addr is one-hot decoded; exactly one register is enabled per commit.
  - With ZERO_REG=1, a commit to address 0 pops the queue but leaves Q0=0.
  - Addresses 1..31 are written unconditionally.
- Same-address writes in consecutive cycles: the last committed value wins; no merging.
- State machine: IDLE, DRAIN, SWEEP.
  - IDLE: if clr_req=1 go to DRAIN. A write accepted on the same edge still enters the queue and is drained before the sweep.
  - DRAIN: wr_ready=0; continue committing queued entries. When count==0, go to SWEEP with sweep counter=0.
  - SWEEP: wr_ready=0; each edge zeroes register[counter] and increments the 5-bit counter.
    - After the edge that clears register 31, go to IDLE and assert clr_done for exactly that following cycle.
    - The sweep lasts exactly 32 cycles.
- clr_req is ignored outside IDLE; holding it high after clr_done starts a new clear.
- The counter does not wrap past 31; the exit to IDLE happens on counter==31.
- No combinational path from wr_data to Q*; Q* are register outputs only.

Decomposition:
- Shared package holds:
  - REG_COUNT=32 and ADDR_W=5.
  - The state enum {IDLE, DRAIN, SWEEP}.
  - The write-entry struct {addr[4:0], data[WIDTH-1:0]}.
- One natural sub-module: wp_fifo2, a 2-entry FIFO with push/pop/count/head outputs.
- Decoder, register array and FSM stay in the top module.

Test Plan:
- Reset then idle → all Q0..Q31 = 0; wr_ready=1; busy=0; clr_done=0.
- Write addr 5 data 0xDEADBEEF accepted at edge N → Q5=0xDEADBEEF after edge N+1; all other Q unchanged.
- Write addr 0 data 0xFFFFFFFF with ZERO_REG=1 → Q0 stays 0; queue drains; busy returns to 0.
- Back-to-back writes every cycle (addr 1..31, data=addr*0x01010101) → wr_ready never drops; each Qk correct one edge after its accept; then addr 7 written twice (0x11 then 0x22) in consecutive cycles → Q7=0x22.
- Fill registers, stall commits by accepting two writes, then assert clr_req with wr_valid high in the same cycle:
  - that write is accepted and committed;
  - wr_ready=0 for the whole DRAIN+SWEEP (2+32 cycles);
  - all Q=0 afterwards;
  - clr_done pulses exactly once.
- Assert reset mid-sweep at counter=10 → next cycle all Q=0, state IDLE, no clr_done pulse, wr_ready=1.

Source files
------------

// File: rtl/regfile_write_port_pkg.sv
// Shared types and sizes for the register-file write port.
package regfile_write_port_pkg;

  localparam int unsigned REG_COUNT = 32;
  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned DATA_W    = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    SWEEP = 2'd2
  } wp_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

  function automatic logic [REG_COUNT-1:0] onehot_addr(input logic [ADDR_W-1:0] a);
    return REG_COUNT'(1) << a;
  endfunction

endpackage

// File: rtl/wp_fifo2.sv
// Two-entry FIFO of pending write-back entries; head is valid whenever count_o != 0.
import regfile_write_port_pkg::*;

module wp_fifo2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  wr_entry_t  push_data_i,
  input  logic       pop_i,
  output logic [1:0] count_o,
  output wr_entry_t  head_o
);

  wr_entry_t  mem_q [2];
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] count_q, count_d;
  logic       do_push, do_pop;

  // A push into a full FIFO is only legal when the head leaves on the same edge.
  always_comb begin
    do_pop   = pop_i && (count_q != 2'd0);
    do_push  = push_i && ((count_q != 2'd2) || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_pop)  rd_ptr_d = ~rd_ptr_q;
    if (do_push) wr_ptr_d = ~wr_ptr_q;
    if (do_push && !do_pop)      count_d = count_q + 2'd1;
    else if (do_pop && !do_push) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/regfile_write_port.sv
// Write side of the 32 x WIDTH register file: queued write-back, one commit per
// cycle, and a drain-then-sweep bulk clear.
import regfile_write_port_pkg::*;

module regfile_write_port #(
  parameter int unsigned WIDTH    = DATA_W,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              clr_req,
  output logic              clr_done,
  output logic              busy,
  output logic [WIDTH-1:0]  Q0,
  output logic [WIDTH-1:0]  Q1,
  output logic [WIDTH-1:0]  Q2,
  output logic [WIDTH-1:0]  Q3,
  output logic [WIDTH-1:0]  Q4,
  output logic [WIDTH-1:0]  Q5,
  output logic [WIDTH-1:0]  Q6,
  output logic [WIDTH-1:0]  Q7,
  output logic [WIDTH-1:0]  Q8,
  output logic [WIDTH-1:0]  Q9,
  output logic [WIDTH-1:0]  Q10,
  output logic [WIDTH-1:0]  Q11,
  output logic [WIDTH-1:0]  Q12,
  output logic [WIDTH-1:0]  Q13,
  output logic [WIDTH-1:0]  Q14,
  output logic [WIDTH-1:0]  Q15,
  output logic [WIDTH-1:0]  Q16,
  output logic [WIDTH-1:0]  Q17,
  output logic [WIDTH-1:0]  Q18,
  output logic [WIDTH-1:0]  Q19,
  output logic [WIDTH-1:0]  Q20,
  output logic [WIDTH-1:0]  Q21,
  output logic [WIDTH-1:0]  Q22,
  output logic [WIDTH-1:0]  Q23,
  output logic [WIDTH-1:0]  Q24,
  output logic [WIDTH-1:0]  Q25,
  output logic [WIDTH-1:0]  Q26,
  output logic [WIDTH-1:0]  Q27,
  output logic [WIDTH-1:0]  Q28,
  output logic [WIDTH-1:0]  Q29,
  output logic [WIDTH-1:0]  Q30,
  output logic [WIDTH-1:0]  Q31
);

  wp_state_t         state_q, state_d;
  logic [ADDR_W-1:0] sweep_cnt_q, sweep_cnt_d;
  logic              clr_done_q, clr_done_d;
  logic [1:0]        fifo_count;
  wr_entry_t         fifo_head;
  wr_entry_t         push_entry;
  logic              push, pop;
  logic [REG_COUNT-1:0] wr_en;
  logic [WIDTH-1:0]  regs_q [REG_COUNT];
  logic [WIDTH-1:0]  regs_d [REG_COUNT];

  always_comb begin
    push_entry.addr = wr_addr;
    push_entry.data = DATA_W'(wr_data);
  end

  wp_fifo2 u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .count_o     (fifo_count),
    .head_o      (fifo_head)
  );

  // Next state, handshake and commit control.
  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    clr_done_d  = 1'b0;
    wr_ready    = 1'b0;
    busy        = (state_q != IDLE) || (fifo_count != 2'd0);
    case (state_q)
      IDLE: begin
        wr_ready = (fifo_count < 2'd2);
        if (clr_req) state_d = DRAIN;
      end
      DRAIN: begin
        if (fifo_count == 2'd0) begin
          state_d     = SWEEP;
          sweep_cnt_d = '0;
        end
      end
      SWEEP: begin
        if (sweep_cnt_q == ADDR_W'(REG_COUNT - 1)) begin
          state_d     = IDLE;
          sweep_cnt_d = '0;
          clr_done_d  = 1'b1;
        end else begin
          sweep_cnt_d = sweep_cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    push = wr_valid && wr_ready;
    pop  = (fifo_count != 2'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sweep_cnt_q <= '0;
      clr_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
      clr_done_q  <= clr_done_d;
    end
  end

  // One-hot commit decode; the sweep clear wins over a commit to the same register.
  always_comb begin
    wr_en = pop ? onehot_addr(fifo_head.addr) : '0;
    if (ZERO_REG != 0) wr_en[0] = 1'b0;
    for (int i = 0; i < REG_COUNT; i++) begin
      regs_d[i] = regs_q[i];
      if ((state_q == SWEEP) && (sweep_cnt_q == ADDR_W'(i))) regs_d[i] = '0;
      else if (wr_en[i])                                     regs_d[i] = WIDTH'(fifo_head.data);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign clr_done = clr_done_q;

  assign Q0  = regs_q[0];
  assign Q1  = regs_q[1];
  assign Q2  = regs_q[2];
  assign Q3  = regs_q[3];
  assign Q4  = regs_q[4];
  assign Q5  = regs_q[5];
  assign Q6  = regs_q[6];
  assign Q7  = regs_q[7];
  assign Q8  = regs_q[8];
  assign Q9  = regs_q[9];
  assign Q10 = regs_q[10];
  assign Q11 = regs_q[11];
  assign Q12 = regs_q[12];
  assign Q13 = regs_q[13];
  assign Q14 = regs_q[14];
  assign Q15 = regs_q[15];
  assign Q16 = regs_q[16];
  assign Q17 = regs_q[17];
  assign Q18 = regs_q[18];
  assign Q19 = regs_q[19];
  assign Q20 = regs_q[20];
  assign Q21 = regs_q[21];
  assign Q22 = regs_q[22];
  assign Q23 = regs_q[23];
  assign Q24 = regs_q[24];
  assign Q25 = regs_q[25];
  assign Q26 = regs_q[26];
  assign Q27 = regs_q[27];
  assign Q28 = regs_q[28];
  assign Q29 = regs_q[29];
  assign Q30 = regs_q[30];
  assign Q31 = regs_q[31];

endmodule

// File: tb/tb_regfile_write_port.sv
// Directed bench for regfile_write_port: writes, zero register, back-to-back
// stream, drain+sweep clear and reset during a sweep.
module tb_regfile_write_port;

  logic        clk;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        clr_req;
  logic        clr_done;
  logic        busy;
  wire  [31:0] q [32];

  logic [31:0] exp_q [32];
  int          n_vec;
  int          n_miss;

  regfile_write_port #(.WIDTH(32), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .clr_req(clr_req),
    .clr_done(clr_done), .busy(busy),
    .Q0(q[0]),   .Q1(q[1]),   .Q2(q[2]),   .Q3(q[3]),
    .Q4(q[4]),   .Q5(q[5]),   .Q6(q[6]),   .Q7(q[7]),
    .Q8(q[8]),   .Q9(q[9]),   .Q10(q[10]), .Q11(q[11]),
    .Q12(q[12]), .Q13(q[13]), .Q14(q[14]), .Q15(q[15]),
    .Q16(q[16]), .Q17(q[17]), .Q18(q[18]), .Q19(q[19]),
    .Q20(q[20]), .Q21(q[21]), .Q22(q[22]), .Q23(q[23]),
    .Q24(q[24]), .Q25(q[25]), .Q26(q[26]), .Q27(q[27]),
    .Q28(q[28]), .Q29(q[29]), .Q30(q[30]), .Q31(q[31])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 32; i++) chk($sformatf("%s.Q%0d", tag, i), q[i], exp_q[i]);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ready_low;
    int pulses;
    int pulse_at;
    bit saw_end;

    n_vec    = 0;
    n_miss   = 0;
    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    clr_req  = 1'b0;
    for (int i = 0; i < 32; i++) exp_q[i] = '0;

    // Reset then idle
    step();
    step();
    reset = 1'b0;
    step();
    check_all("reset");
    chk("reset.wr_ready", 32'(wr_ready), 32'd1);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.clr_done", 32'(clr_done), 32'd0);

    // Single write: visible one edge after accept
    wr_valid = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    chk("w5.ready", 32'(wr_ready), 32'd1);
    step();
    wr_valid = 1'b0;
    chk("w5.not_yet", q[5], 32'h0);
    chk("w5.busy", 32'(busy), 32'd1);
    step();
    exp_q[5] = 32'hDEADBEEF;
    check_all("w5");
    chk("w5.busy_after", 32'(busy), 32'd0);

    // Zero register write is dropped
    wr_valid = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    step();
    wr_valid = 1'b0;
    step();
    chk("w0.q0", q[0], 32'h0);
    chk("w0.busy", 32'(busy), 32'd0);

    // Back-to-back stream over addresses 1..31
    for (int k = 1; k < 32; k++) begin
      wr_valid = 1'b1; wr_addr = 5'(k); wr_data = 32'(k) * 32'h01010101;
      chk($sformatf("b2b.ready%0d", k), 32'(wr_ready), 32'd1);
      step();
      if (k > 1) begin
        exp_q[k-1] = 32'(k - 1) * 32'h01010101;
        chk($sformatf("b2b.Q%0d", k - 1), q[k-1], exp_q[k-1]);
      end
    end
    wr_addr = 5'd7; wr_data = 32'h11;
    step();
    exp_q[31] = 32'h1F1F1F1F;
    chk("b2b.Q31", q[31], exp_q[31]);
    wr_addr = 5'd7; wr_data = 32'h22;
    step();
    chk("same7.first", q[7], 32'h11);
    wr_valid = 1'b0;
    step();
    exp_q[7] = 32'h22;
    check_all("same7");

    // Clear with a write accepted on the same edge as clr_req
    wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
    step();
    wr_addr = 5'd9; wr_data = 32'h99; clr_req = 1'b1;
    chk("clr.ready_at_req", 32'(wr_ready), 32'd1);
    step();
    wr_valid = 1'b0; clr_req = 1'b0;
    chk("clr.q3", q[3], 32'h33);
    ready_low = 0; pulses = 0; pulse_at = -1; saw_end = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 1) chk("clr.q9", q[9], 32'h99);
      if (!wr_ready && !saw_end) ready_low++;
      else saw_end = 1'b1;
      if (clr_done) begin
        pulses++;
        pulse_at = i;
      end
      step();
    end
    chk("clr.ready_low_cycles", 32'(ready_low), 32'd34);
    chk("clr.done_pulses", 32'(pulses), 32'd1);
    chk("clr.done_at", 32'(pulse_at), 32'd34);
    for (int i = 0; i < 32; i++) exp_q[i] = '0;
    check_all("clr");
    chk("clr.busy", 32'(busy), 32'd0);

    // Reset while the sweep counter is at 10
    wr_valid = 1'b1; wr_addr = 5'd12; wr_data = 32'h0000000C;
    step();
    wr_addr = 5'd31; wr_data = 32'hABCD0031;
    step();
    wr_valid = 1'b0;
    step();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int i = 0; i < 11; i++) step();
    chk("mid.q12_pending", q[12], 32'h0000000C);
    chk("mid.q31_pending", q[31], 32'hABCD0031);
    chk("mid.ready", 32'(wr_ready), 32'd0);
    chk("mid.busy", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_all("mid_rst");
    chk("mid_rst.ready", 32'(wr_ready), 32'd1);
    chk("mid_rst.busy", 32'(busy), 32'd0);
    pulses = 0; ready_low = 0;
    for (int i = 0; i < 40; i++) begin
      if (clr_done) pulses++;
      if (!wr_ready) ready_low++;
      step();
    end
    chk("mid_rst.no_done", 32'(pulses), 32'd0);
    chk("mid_rst.ready_held", 32'(ready_low), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
